// File: rtl/msg_scroll_sched.sv
// Scheduler that grants one of NREQ message sources to the hex scroller and sequences load/hold/scroll/release.
// Optional SCHED_FIXED_PRIO_EN: fixed lowest-index priority with preemption of a message still in HOLD.
module msg_scroll_sched #(
    parameter int NREQ       = 3,
    parameter int DIGITS     = 10,
    parameter int HOLD_TICKS = 3,
    parameter int ROTATIONS  = 1,
    parameter logic [4*DIGITS-1:0] IDLE_PAT = {DIGITS{4'hb}}
) (
    input  logic                     clk3hz,
    input  logic                     clr,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*4*DIGITS-1:0] msg_flat,
    output logic [4*DIGITS-1:0]      number_out,
    output logic                     state_out,
    output logic [NREQ-1:0]          ack,
    output logic                     busy,
    output logic [1:0]               cur_src,
    output logic [1:0]               fsm_state
);
    localparam int MW    = 4 * DIGITS;
    localparam int SCR_T = ROTATIONS * DIGITS;
    localparam int TMAX  = (SCR_T > HOLD_TICKS) ? SCR_T : HOLD_TICKS;
    localparam int TW    = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_SCROLL = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [TW-1:0]   tcnt, tcnt_nx;
    logic [MW-1:0]   number_nx;
    logic            state_out_nx, busy_nx;
    logic [NREQ-1:0] ack_nx;
    logic [1:0]      cur_nx;
    logic [1:0]      win;
    logic [MW-1:0]   win_msg;
    logic            any_req, cur_req, preempt, abort, tcnt_zero;
`ifndef SCHED_FIXED_PRIO_EN
    logic [1:0]      last, last_nx;
    logic            hi_found;
`endif

    // Handshake: req[i] is a level that must stay high for the whole message; ack[i] pulses one tick on completion.
    always_comb begin
        any_req = |req;
        win     = '0;
`ifdef SCHED_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--)
            if (req[i]) win = 2'(i);
`else
        // Round-robin: first set index above last, otherwise the lowest set index.
        hi_found = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (req[i] && (i > int'(last))) begin
                win      = 2'(i);
                hi_found = 1'b1;
            end
        if (!hi_found)
            for (int i = NREQ - 1; i >= 0; i--)
                if (req[i]) win = 2'(i);
`endif
        win_msg = msg_flat[MW-1:0];
        cur_req = 1'b0;
        preempt = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == 2'(i)) win_msg = msg_flat[i*MW +: MW];
            if (cur_src == 2'(i)) cur_req = req[i];
`ifdef SCHED_FIXED_PRIO_EN
            if (req[i] && (i < int'(cur_src))) preempt = 1'b1;
`endif
        end
        tcnt_zero = (tcnt == '0);
        abort     = (state != S_IDLE) && (!cur_req || ((state == S_HOLD) && preempt));
    end

    always_ff @(posedge clk3hz or negedge clr) begin
        if (!clr) begin
            state      <= S_IDLE;
            tcnt       <= '0;
            number_out <= IDLE_PAT;
            state_out  <= 1'b1;
            ack        <= '0;
            busy       <= 1'b0;
            cur_src    <= '0;
`ifndef SCHED_FIXED_PRIO_EN
            last       <= 2'(NREQ - 1);
`endif
        end else begin
            state      <= state_nx;
            tcnt       <= tcnt_nx;
            number_out <= number_nx;
            state_out  <= state_out_nx;
            ack        <= ack_nx;
            busy       <= busy_nx;
            cur_src    <= cur_nx;
`ifndef SCHED_FIXED_PRIO_EN
            last       <= last_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (any_req) state_nx = S_HOLD;
            S_HOLD:   if (abort) state_nx = S_IDLE;
                      else if (tcnt_zero) state_nx = S_SCROLL;
            S_SCROLL: if (abort || tcnt_zero) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        number_nx    = number_out;
        state_out_nx = state_out;
        busy_nx      = busy;
        cur_nx       = cur_src;
        tcnt_nx      = tcnt;
        ack_nx       = '0;
`ifndef SCHED_FIXED_PRIO_EN
        last_nx      = last;
`endif
        case (state)
            S_IDLE: begin
                state_out_nx = 1'b1;
                if (any_req) begin
                    number_nx = win_msg;
                    cur_nx    = win;
                    busy_nx   = 1'b1;
                    tcnt_nx   = TW'(HOLD_TICKS - 1);
`ifndef SCHED_FIXED_PRIO_EN
                    last_nx   = win;
`endif
                end else begin
                    number_nx = IDLE_PAT;
                    busy_nx   = 1'b0;
                end
            end
            S_HOLD, S_SCROLL: begin
                if (abort || tcnt_zero) begin
                    if ((state == S_HOLD) && !abort) begin
                        state_out_nx = 1'b0;
                        tcnt_nx      = TW'(SCR_T - 1);
                    end else begin
                        state_out_nx = 1'b1;
                        number_nx    = IDLE_PAT;
                        busy_nx      = 1'b0;
                        if (!abort)
                            for (int i = 0; i < NREQ; i++)
                                if (cur_src == 2'(i)) ack_nx[i] = 1'b1;
                    end
                end else begin
                    tcnt_nx = tcnt - 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign fsm_state = state;
endmodule

// File: tb/tb_msg_scroll_sched.sv
// Bench for msg_scroll_sched: message-age reference model checked every tick, directed scenarios, random traffic.
module tb_msg_scroll_sched;
    localparam int NREQ = 3;
    localparam int HOLD = 3;
    localparam int RD   = 10;
    localparam int MW   = 40;
    localparam logic [MW-1:0] IDLE = 40'hbbbbbbbbbb;
`ifdef SCHED_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic                 clk3hz = 1'b0;
    logic                 clr;
    logic [NREQ-1:0]      req;
    logic [NREQ*MW-1:0]   msg_flat;
    logic [MW-1:0]        number_out;
    logic                 state_out;
    logic [NREQ-1:0]      ack;
    logic                 busy;
    logic [1:0]           cur_src;
    logic [1:0]           fsm_state;

    int total = 0;
    int bad   = 0;

    msg_scroll_sched dut (
        .clk3hz(clk3hz), .clr(clr), .req(req), .msg_flat(msg_flat),
        .number_out(number_out), .state_out(state_out), .ack(ack),
        .busy(busy), .cur_src(cur_src), .fsm_state(fsm_state)
    );

    always #5 clk3hz = ~clk3hz;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a message is described by its source, captured text and age in ticks since grant.
    bit              m_active;
    int              m_src, m_age, m_last;
    logic [MW-1:0]   m_msg;
    logic [NREQ-1:0] m_ack;

    function automatic int pick(input logic [NREQ-1:0] r, input int lst);
        if (FIXED) begin
            for (int i = 0; i < NREQ; i++) if (r[i]) return i;
        end else begin
            for (int k = 1; k <= NREQ; k++) if (r[(lst + k) % NREQ]) return (lst + k) % NREQ;
        end
        return 0;
    endfunction

    always @(posedge clk3hz) begin
        bit lower;
        if (!clr) begin
            m_active = 0; m_src = 0; m_age = 0; m_last = NREQ - 1; m_ack = '0; m_msg = IDLE;
        end else begin
            m_ack = '0;
            if (m_active) begin
                m_age++;
                lower = 0;
                for (int j = 0; j < m_src; j++) if (req[j]) lower = 1;
                if (!req[m_src] || (FIXED && lower && m_age <= HOLD)) m_active = 0;
                else if (m_age == HOLD + RD) begin
                    m_active = 0;
                    m_ack[m_src] = 1'b1;
                end
            end else if (req != '0) begin
                m_src    = pick(req, m_last);
                m_last   = m_src;
                m_active = 1;
                m_age    = 0;
                m_msg    = msg_flat[m_src*MW +: MW];
            end
        end
        #2;
        chk("number_out", 64'(number_out), 64'(m_active ? m_msg : IDLE));
        chk("state_out", 64'(state_out), 64'(m_active ? (m_age < HOLD) : 1'b1));
        chk("busy", 64'(busy), 64'(m_active));
        chk("ack", 64'(ack), 64'(m_ack));
        if (m_active) chk("cur_src", 64'(cur_src), 64'(m_src));
    end

    task automatic do_reset();
        @(negedge clk3hz) clr = 1'b0;
        @(negedge clk3hz) clr = 1'b1;
    endtask

    initial begin
        int n;
        logic [NREQ-1:0] seen;
        int exp_src[4] = '{0, 1, 2, 0};
        clr = 1'b0; req = '0; msg_flat = '0;
        repeat (3) @(posedge clk3hz);
        @(negedge clk3hz) clr = 1'b1;

        // idle after reset
        repeat (5) @(posedge clk3hz);
        #3;
        chk("idle_number", 64'(number_out), 64'(40'hbbbbbbbbbb));
        chk("idle_state", 64'(state_out), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);

        // single message from source 0, text changed after grant
        @(negedge clk3hz);
        req = 3'b001;
        msg_flat = {40'h1111111111, 40'h2222222222, 40'h0123456789};
        @(posedge clk3hz); #3;
        chk("e0_number", 64'(number_out), 64'(40'h0123456789));
        chk("e0_state", 64'(state_out), 64'd1);
        @(negedge clk3hz) msg_flat[MW-1:0] = 40'hfedcba9876;
        repeat (3) @(posedge clk3hz);
        #3 chk("e3_state", 64'(state_out), 64'd0);
        repeat (10) @(posedge clk3hz);
        #3;
        chk("e13_ack", 64'(ack), 64'(3'b001));
        chk("e13_number", 64'(number_out), 64'(40'hbbbbbbbbbb));
        @(negedge clk3hz) req = '0;
        @(posedge clk3hz);
        #3 chk("e14_ack", 64'(ack), 64'd0);

        // all sources requesting: round-robin order, 13 ticks grant-to-ack
        do_reset();
        @(negedge clk3hz);
        req = 3'b111;
        msg_flat = {40'h2a2a2a2a2a, 40'h1c1c1c1c1c, 40'h0e0e0e0e0e};
        for (int g = 0; g < 4; g++) begin
            @(posedge clk3hz); #3;
            if (!FIXED) chk("rr_grant", 64'(cur_src), 64'(exp_src[g]));
            n = 0;
            do begin
                @(posedge clk3hz); #3;
                n++;
            end while (ack == '0 && n < 40);
            chk("rr_ack_delay", 64'(n), 64'd13);
            if (!FIXED) chk("rr_ack_vec", 64'(ack), 64'(3'b001 << exp_src[g]));
        end
        @(negedge clk3hz) req = '0;

        // source 1 drops its request during SCROLL
        do_reset();
        @(negedge clk3hz) req = 3'b010;
        repeat (5) @(posedge clk3hz);
        @(negedge clk3hz) req = '0;
        @(posedge clk3hz); #3;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_number", 64'(number_out), 64'(40'hbbbbbbbbbb));
        seen = '0;
        repeat (20) begin
            @(posedge clk3hz); #3;
            seen |= ack;
        end
        chk("abort_no_ack", 64'(seen), 64'd0);

        // reset mid-message, then pointer starts over
        do_reset();
        @(negedge clk3hz) req = 3'b001;
        repeat (9) @(posedge clk3hz);
        @(negedge clk3hz) clr = 1'b0;
        #1;
        chk("rst_number", 64'(number_out), 64'(40'hbbbbbbbbbb));
        chk("rst_state", 64'(state_out), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_cur", 64'(cur_src), 64'd0);
        @(negedge clk3hz) begin req = 3'b100; clr = 1'b1; end
        @(posedge clk3hz);
        #3 chk("post_rst_src2", 64'(cur_src), 64'd2);
        @(negedge clk3hz) begin clr = 1'b0; req = 3'b101; end
        @(negedge clk3hz) clr = 1'b1;
        @(posedge clk3hz);
        #3 chk("post_rst_src0", 64'(cur_src), 64'd0);

        // random traffic against the model
        do_reset();
        req = '0;
        repeat (4000) begin
            @(negedge clk3hz);
            if (!clr) clr = 1'b1;
            else if ($urandom_range(0, 599) == 0) clr = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 39) == 0) req[i] = ~req[i];
                if ($urandom_range(0, 3) == 0) msg_flat[i*MW +: MW] = {8'($urandom), $urandom};
            end
        end
        @(negedge clk3hz) req = '0;
        repeat (3) @(posedge clk3hz);
        #4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
